// File: rtl/sump_command_parser_if.sv
// rtl/sump_command_parser_if.sv - byte receive and command report bundle for the SUMP command parser
interface sump_command_parser_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_arg;
    logic        error_strobe;

    // Host side: UART receiver feeding bytes, observer of completed commands
    modport master (
        output rx_data,
        output rx_valid,
        input  cmd_valid,
        input  cmd_opcode,
        input  cmd_arg,
        input  error_strobe
    );

    // Parser side
    modport slave (
        input  rx_data,
        input  rx_valid,
        output cmd_valid,
        output cmd_opcode,
        output cmd_arg,
        output error_strobe
    );
endinterface

// File: rtl/sump_command_parser.sv
// rtl/sump_command_parser.sv - SUMP/OLS command parser; optional inter-byte timeout under SUMP_PARSER_TIMEOUT_EN
module sump_command_parser #(
    parameter int CHANNELS       = 32,
    parameter int TRIGGER_STAGES = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                               clock,
    input  logic                               reset,
    sump_command_parser_if.slave               bus,
    output logic                               reset_pulse,
    output logic                               run_pulse,
    output logic                               id_request,
    output logic                               metadata_request,
    output logic [23:0]                        divider,
    output logic [31:0]                        read_count,
    output logic [31:0]                        delay_count,
    output logic [15:0]                        flags,
    output logic [TRIGGER_STAGES*CHANNELS-1:0] trigger_mask,
    output logic [TRIGGER_STAGES*CHANNELS-1:0] trigger_value,
    output logic [TRIGGER_STAGES*32-1:0]       trigger_config,
    output logic [TRIGGER_STAGES*32-1:0]       trigger_edge
);

    // Reject parameter sets the decode cannot represent
    if (CHANNELS < 8 || CHANNELS > 32 || (CHANNELS % 8) != 0 ||
        TRIGGER_STAGES < 1 || TRIGGER_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("sump_command_parser: illegal parameter combination");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ARG  = 1'b1
    } state_t;

    localparam logic [2:0] LP_STAGES = 3'(TRIGGER_STAGES);

    state_t        r_state;
    logic [7:0]    r_opcode;
    logic [23:0]   r_arg;      // bytes 0..2; byte 3 is taken straight from rx_data
    logic [1:0]    r_cnt;

    logic          r_cmd_valid;
    logic [7:0]    r_cmd_opcode;
    logic [31:0]   r_cmd_arg;
    logic          r_error;
    logic          r_reset_pulse;
    logic          r_run_pulse;
    logic          r_id_request;
    logic          r_metadata_request;
    logic [23:0]   r_divider;
    logic [31:0]   r_read_count;
    logic [31:0]   r_delay_count;
    logic [15:0]   r_flags;
    logic [CHANNELS-1:0] r_mask   [TRIGGER_STAGES];
    logic [CHANNELS-1:0] r_value  [TRIGGER_STAGES];
    logic [31:0]         r_config [TRIGGER_STAGES];
    logic [31:0]         r_edge   [TRIGGER_STAGES];

    logic          w_done;
    logic [7:0]    w_op;
    logic [31:0]    w_arg;
    logic [1:0]    w_stage;
    logic          w_legal;
    logic          w_timeout;

`ifdef SUMP_PARSER_TIMEOUT_EN
    localparam int LP_TW = ($clog2(TIMEOUT_CYCLES + 1) > 17) ? $clog2(TIMEOUT_CYCLES + 1) : 17;
    localparam logic [LP_TW-1:0] LP_TLAST = LP_TW'(TIMEOUT_CYCLES - 1);
    logic [LP_TW-1:0] r_idle;
`endif

    // Identify a command completing this cycle and classify its opcode
    always_comb begin
        w_done = 1'b0;
        w_op   = r_opcode;
        w_arg  = {bus.rx_data, r_arg};
        if (bus.rx_valid) begin
            if (r_state == S_IDLE && !bus.rx_data[7]) begin
                w_done = 1'b1;
                w_op   = bus.rx_data;
                w_arg  = '0;
            end else if (r_state == S_ARG && r_cnt == 2'd3) begin
                w_done = 1'b1;
            end
        end
        w_stage = w_op[3:2];
        w_legal = (w_op <= 8'h04) ||
                  (w_op >= 8'h80 && w_op <= 8'h84) ||
                  (w_op[7:4] == 4'hC && {1'b0, w_stage} < LP_STAGES);
`ifdef SUMP_PARSER_TIMEOUT_EN
        // A byte in the expiry cycle takes priority over the timeout
        w_timeout = (r_state == S_ARG) && !bus.rx_valid && (r_idle == LP_TLAST);
`else
        w_timeout = 1'b0;
`endif
    end

    // Command FSM, argument assembly, register writes and one-cycle strobes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_opcode           <= '0;
            r_arg              <= '0;
            r_cnt              <= '0;
            r_cmd_valid        <= 1'b0;
            r_cmd_opcode       <= '0;
            r_cmd_arg          <= '0;
            r_error            <= 1'b0;
            r_reset_pulse      <= 1'b0;
            r_run_pulse        <= 1'b0;
            r_id_request       <= 1'b0;
            r_metadata_request <= 1'b0;
            r_divider          <= '0;
            r_read_count       <= '0;
            r_delay_count      <= '0;
            r_flags            <= '0;
            for (int s = 0; s < TRIGGER_STAGES; s++) begin
                r_mask[s]   <= '0;
                r_value[s]  <= '0;
                r_config[s] <= '0;
                r_edge[s]   <= '0;
            end
`ifdef SUMP_PARSER_TIMEOUT_EN
            r_idle             <= '0;
`endif
        end else begin
            r_cmd_valid        <= w_done;
            r_error            <= (w_done && !w_legal) || w_timeout;
            r_reset_pulse      <= 1'b0;
            r_run_pulse        <= 1'b0;
            r_id_request       <= 1'b0;
            r_metadata_request <= 1'b0;

            if (w_done) begin
                r_cmd_opcode <= w_op;
                r_cmd_arg    <= w_arg;
                case (w_op)
                    8'h00: r_reset_pulse      <= 1'b1;
                    8'h01: r_run_pulse        <= 1'b1;
                    8'h02: r_id_request       <= 1'b1;
                    8'h04: r_metadata_request <= 1'b1;
                    8'h80: r_divider          <= w_arg[23:0];
                    8'h81: begin
                        r_read_count  <= {16'b0, w_arg[15:0]};
                        r_delay_count <= {16'b0, w_arg[31:16]};
                    end
                    8'h82: r_flags       <= w_arg[15:0];
                    8'h83: r_delay_count <= w_arg;
                    8'h84: r_read_count  <= w_arg;
                    default: begin
                        // Unimplemented stages never match, so they write nothing
                        if (w_op[7:4] == 4'hC) begin
                            for (int s = 0; s < TRIGGER_STAGES; s++) begin
                                if (w_stage == 2'(s)) begin
                                    case (w_op[1:0])
                                        2'd0:    r_mask[s]   <= w_arg[CHANNELS-1:0];
                                        2'd1:    r_value[s]  <= w_arg[CHANNELS-1:0];
                                        2'd2:    r_config[s] <= w_arg;
                                        default: r_edge[s]   <= w_arg;
                                    endcase
                                end
                            end
                        end
                    end
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        r_opcode <= bus.rx_data;
                        if (bus.rx_data[7]) begin
                            r_cnt   <= 2'd0;
                            r_state <= S_ARG;
`ifdef SUMP_PARSER_TIMEOUT_EN
                            r_idle  <= '0;
`endif
                        end
                    end
                end
                default: begin
                    if (bus.rx_valid) begin
                        if (r_cnt == 2'd3) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_arg[{r_cnt, 3'b000} +: 8] <= bus.rx_data;
                        end
                        r_cnt <= r_cnt + 2'd1;
`ifdef SUMP_PARSER_TIMEOUT_EN
                        r_idle <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                        r_idle  <= '0;
                    end else begin
                        r_idle <= r_idle + 1'b1;
`endif
                    end
                end
            endcase
        end
    end

    assign bus.cmd_valid    = r_cmd_valid;
    assign bus.cmd_opcode   = r_cmd_opcode;
    assign bus.cmd_arg      = r_cmd_arg;
    assign bus.error_strobe = r_error;

    assign reset_pulse      = r_reset_pulse;
    assign run_pulse        = r_run_pulse;
    assign id_request       = r_id_request;
    assign metadata_request = r_metadata_request;
    assign divider          = r_divider;
    assign read_count       = r_read_count;
    assign delay_count      = r_delay_count;
    assign flags            = r_flags;

    for (genvar g = 0; g < TRIGGER_STAGES; g++) begin : g_flat
        assign trigger_mask[g*CHANNELS +: CHANNELS] = r_mask[g];
        assign trigger_value[g*CHANNELS +: CHANNELS] = r_value[g];
        assign trigger_config[g*32 +: 32]           = r_config[g];
        assign trigger_edge[g*32 +: 32]             = r_edge[g];
    end

endmodule

// File: doc/sump_command_parser.md
# sump_command_parser

Parametrised SUMP/OLS host-command parser between the UART receiver and the capture engine. It classifies opcode bytes into short (1-byte) and long (opcode + 4 argument bytes) commands and assembles arguments little-endian. It updates the capture configuration registers and emits one-cycle action strobes. Compared with the fixed-decode parser it replaces, it generalises channel width and trigger-stage count, adds an inter-byte timeout, and flags illegal opcodes.

## Interface

Parameters:
- `CHANNELS`, 32 — width of each trigger mask/value register; legal values 8, 16, 24, 32.
- `TRIGGER_STAGES`, 4 — number of implemented trigger stages; legal values 1–4.
- `TIMEOUT_CYCLES`, 100000 — idle cycles allowed between argument bytes before the partial command is discarded.

Ports (name, direction, width, meaning):
- `clock` in 1 — single clock for the whole block.
- `reset` in 1 — asynchronous, active-high.
- `rx_data` in 8 — received byte.
- `rx_valid` in 1 — one-cycle strobe; `rx_data` is valid in that cycle.
- `cmd_valid` out 1 — one-cycle strobe marking a completed command.
- `cmd_opcode` out 8 — opcode of the last completed command.
- `cmd_arg` out 32 — assembled argument of the last completed command; first argument byte is `[7:0]`.
- `error_strobe` out 1 — one-cycle strobe for an illegal opcode or a timeout.
- `reset_pulse`, `run_pulse`, `id_request`, `metadata_request` out 1 each — one-cycle action strobes.
- `divider` out 24 — sample clock divider.
- `read_count` out 32, `delay_count` out 32 — capture counts.
- `flags` out 16 — capture flags.
- `trigger_mask` out `TRIGGER_STAGES*CHANNELS` — stage n occupies slice n.
- `trigger_value` out `TRIGGER_STAGES*CHANNELS` — stage n occupies slice n.
- `trigger_config` out `TRIGGER_STAGES*32` — stage n occupies slice n.
- `trigger_edge` out `TRIGGER_STAGES*32` — stage n occupies slice n.

## Operation

State machine:
- **IDLE:** on `rx_valid`, latch the opcode.
  - If `rx_data[7]` is 0 (short command), dispatch immediately and stay in IDLE.
  - If `rx_data[7]` is 1 (long command), clear the argument byte counter and go to ARG.
- **ARG:** each `rx_valid` stores the byte at position 0..3 of the argument.
  - On byte 3, dispatch and return to IDLE in the same edge.

Short-command decode:
- 0x00 → `reset_pulse`.
- 0x01 → `run_pulse`.
- 0x02 → `id_request`.
- 0x04 → `metadata_request`.
- 0x03 (test mode) → accepted with no side effect.
- Any other short opcode → `error_strobe`.

Long-command decode (arg = assembled 32-bit argument):
- 0x80 → `divider` = arg[23:0].
- 0x81 → `read_count` = {16'b0, arg[15:0]}; `delay_count` = {16'b0, arg[31:16]}.
- 0x82 → `flags` = arg[15:0].
- 0x83 → `delay_count` = arg.
- 0x84 → `read_count` = arg.
- 0xC0–0xCF → stage = opcode[3:2], register = opcode[1:0]:
  - 0 → mask, stores arg[CHANNELS-1:0].
  - 1 → value, stores arg[CHANNELS-1:0].
  - 2 → config, stores full 32 bits.
  - 3 → edge, stores full 32 bits.
  - stage ≥ `TRIGGER_STAGES` → no write, `error_strobe`.
- Any other long opcode → no write, `error_strobe`.

General rules:
- Every completed command, legal or not, asserts `cmd_valid` and updates `cmd_opcode`/`cmd_arg`.
- Short commands report `cmd_arg` = 0.
- Byte 0x00 arriving in ARG is argument data, never a reset.
- The 0x00 opcode only pulses `reset_pulse`; configuration registers keep their values.

## Timing

- All outputs are registered. Reset value of every output, register, and strobe is 0; state resets to IDLE.
- Latency: register updates, `cmd_valid`, and action strobes appear on the clock edge that samples the final byte, so they are visible the cycle after that byte's `rx_valid`.
- All strobes are high for exactly one cycle.
- Back-to-back `rx_valid` on consecutive cycles is accepted without loss. A byte arriving in the cycle `cmd_valid` is high is treated as a new opcode.
- Asserting `reset` mid-command discards the partial command with no strobes.
- Argument assembly has no wrap-around: the counter is 2 bits and exits at 3.

## Configuration

`SUMP_PARSER_TIMEOUT_EN`:
- **Defined:** a 17-bit-minimum idle counter runs in ARG and clears on each `rx_valid`.
  - After `TIMEOUT_CYCLES` cycles without a byte: return to IDLE, pulse `error_strobe`, leave `cmd_valid` low, write nothing.
  - If `rx_valid` arrives in the expiry cycle, the byte wins and no timeout occurs.
- **Undefined:** no counter is built; ARG waits indefinitely and `error_strobe` comes only from illegal opcodes.

## Test plan

- Send 0x02 → `id_request` and `cmd_valid` pulse once, with `cmd_opcode`=0x02, `cmd_arg`=0 and all config registers unchanged.
- Send 0x81 7C 00 7C 00 → `read_count`=0x007C, `delay_count`=0x007C, with `cmd_arg`=0x007C007C one cycle after the last byte.
- Send 0xC0 00 00 00 00, then 0x82 3A 08 00 00, then 0x01 → zero bytes are not decoded as reset, `trigger_mask` stage 0 = 0, `flags`=0x083A and `run_pulse` fire once.
- With `TRIGGER_STAGES`=2, send 0xC8 FF FF FF FF → `error_strobe` and `cmd_valid` pulse, with the stage 2 register absent and stages 0–1 unchanged; send 0x05 → `error_strobe`.
- With `SUMP_PARSER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, send 0x80 11 22, idle 100 cycles, then 0x01 → `error_strobe` pulses, `divider` stays 0, `run_pulse` fires.
- Send 0x80 AA, assert `reset` for one cycle, then send 0x80 01 02 03 04 → the first command is lost, `divider`=0x030201, and `cmd_valid` pulses exactly once.
